mem_access_unit: RTL and testbench

//  Parametrised memory-stage controller for the multi-cycle core; successor to the fixed one-cycle MEM stage.

---
 rtl/mem_pkg.sv | 29 ++
 rtl/mem_access_unit_if.sv | 47 ++++
 rtl/mem_lane_steer.sv | 56 +++++
 rtl/mem_access_unit.sv | 147 ++++++++++++++
 tb/tb_mem_access_unit.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types for the memory-stage controller: access size encodings,
// FSM state type and the byte-enable mask for each access size.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2,
    MEM_D = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mau_state_e;

  localparam int unsigned WAIT_CNT_W = 8;

  function automatic logic [7:0] size_mask(input mem_size_e size);
    case (size)
      MEM_B:   return 8'h01;
      MEM_H:   return 8'h03;
      MEM_W:   return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline tokens plus data-memory bus of the memory stage; the controller
// uses the master view, the pipeline/memory model the slave view.
interface mem_access_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int SW = XLEN / 8;

  logic              ALU_kick_up;
  logic [ADDR_W-1:0] ALU_result;
  logic [XLEN-1:0]   reg_read_data_2;
  logic              Controller_memwrite;
  logic              Controller_memread;
  logic [1:0]        Controller_memsize;
  logic              Controller_memunsigned;

  logic              Data_mem_req;
  logic              Data_mem_we;
  logic [ADDR_W-1:0] Data_mem_addr;
  logic [XLEN-1:0]   Data_mem_wdata;
  logic [SW-1:0]     Data_mem_wstrb;
  logic              Data_mem_ack;
  logic [XLEN-1:0]   Data_mem_rdata;

  logic [XLEN-1:0]   MEM_read_data;
  logic              MEM_kick_up;
  logic              MEM_misaligned;
  logic              MEM_timeout;
  logic              MEM_busy;

  modport master (
    input  ALU_kick_up, ALU_result, reg_read_data_2, Controller_memwrite,
           Controller_memread, Controller_memsize, Controller_memunsigned,
           Data_mem_ack, Data_mem_rdata,
    output Data_mem_req, Data_mem_we, Data_mem_addr, Data_mem_wdata, Data_mem_wstrb,
           MEM_read_data, MEM_kick_up, MEM_misaligned, MEM_timeout, MEM_busy
  );

  modport slave (
    output ALU_kick_up, ALU_result, reg_read_data_2, Controller_memwrite,
           Controller_memread, Controller_memsize, Controller_memunsigned,
           Data_mem_ack, Data_mem_rdata,
    input  Data_mem_req, Data_mem_we, Data_mem_addr, Data_mem_wdata, Data_mem_wstrb,
           MEM_read_data, MEM_kick_up, MEM_misaligned, MEM_timeout, MEM_busy
  );

endinterface

// File: rtl/mem_lane_steer.sv
// Combinational byte-lane steering: store shift/strobe and misalignment on
// the issue side, load shift and sign/zero extension on the return side.
module mem_lane_steer
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]             st_addr_lo_i,
  input  mem_size_e              st_size_i,
  input  logic [XLEN-1:0]        st_data_i,
  output logic [XLEN-1:0]        st_wdata_o,
  output logic [XLEN/8-1:0]      st_wstrb_o,
  output logic                   st_misaligned_o,
  input  logic [$clog2(XLEN/8)-1:0] ld_lane_i,
  input  mem_size_e              ld_size_i,
  input  logic                   ld_unsigned_i,
  input  logic [XLEN-1:0]        ld_rdata_i,
  output logic [XLEN-1:0]        ld_data_o
);
  localparam int SW = XLEN / 8;
  localparam int LW = $clog2(SW);

  logic [LW-1:0]      st_lane;
  logic [XLEN-1:0]    ld_shift;
  logic signed [7:0]  ld_b;
  logic signed [15:0] ld_h;
  logic signed [31:0] ld_w;

  assign st_lane = st_addr_lo_i[LW-1:0];

  always_comb begin
    st_wdata_o = st_data_i << {st_lane, 3'b000};
    st_wstrb_o = SW'(size_mask(st_size_i)) << st_lane;
    case (st_size_i)
      MEM_B:   st_misaligned_o = 1'b0;
      MEM_H:   st_misaligned_o = st_addr_lo_i[0];
      MEM_W:   st_misaligned_o = |st_addr_lo_i[1:0];
      // A double access only exists on a 64-bit datapath.
      default: st_misaligned_o = (XLEN == 64) ? |st_addr_lo_i : 1'b1;
    endcase
  end

  always_comb begin
    ld_shift = ld_rdata_i >> {ld_lane_i, 3'b000};
    ld_b     = ld_shift[7:0];
    ld_h     = ld_shift[15:0];
    ld_w     = ld_shift[31:0];
    case (ld_size_i)
      MEM_B:   ld_data_o = ld_unsigned_i ? XLEN'(ld_shift[7:0])  : XLEN'(ld_b);
      MEM_H:   ld_data_o = ld_unsigned_i ? XLEN'(ld_shift[15:0]) : XLEN'(ld_h);
      MEM_W:   ld_data_o = ld_unsigned_i ? XLEN'(ld_shift[31:0]) : XLEN'(ld_w);
      default: ld_data_o = ld_shift;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage controller: takes the ALU token, issues one data-memory
// request with req/ack handshake and timeout, and returns the writeback token.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input logic               clk,
  input logic               reset,
  mem_access_unit_if.master bus
);
  localparam int SW = XLEN / 8;
  localparam int LW = $clog2(SW);

  mau_state_e             state_q;
  logic [WAIT_CNT_W-1:0]  cnt_q;
  logic [WAIT_CNT_W-1:0]  cnt_d;
  logic                   req_q;
  logic                   we_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [XLEN-1:0]        wdata_q;
  logic [SW-1:0]          wstrb_q;
  mem_size_e              size_q;
  logic                   uns_q;
  logic [LW-1:0]          lane_q;
  logic [XLEN-1:0]        rdata_q;
  logic                   kick_q;
  logic                   mis_q;
  logic                   to_q;
  logic                   busy_q;

  mem_size_e              size_in;
  logic                   mem_op;
  logic [XLEN-1:0]        st_wdata;
  logic [SW-1:0]          st_wstrb;
  logic                   st_mis;
  logic [XLEN-1:0]        ld_data;

  assign size_in = mem_size_e'(bus.Controller_memsize);
  assign mem_op  = bus.Controller_memwrite | bus.Controller_memread;
  assign cnt_d   = cnt_q + 1'b1;

  mem_lane_steer #(.XLEN(XLEN)) u_steer (
    .st_addr_lo_i    (bus.ALU_result[2:0]),
    .st_size_i       (size_in),
    .st_data_i       (bus.reg_read_data_2),
    .st_wdata_o      (st_wdata),
    .st_wstrb_o      (st_wstrb),
    .st_misaligned_o (st_mis),
    .ld_lane_i       (lane_q),
    .ld_size_i       (size_q),
    .ld_unsigned_i   (uns_q),
    .ld_rdata_i      (bus.Data_mem_rdata),
    .ld_data_o       (ld_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      size_q  <= MEM_B;
      uns_q   <= 1'b0;
      lane_q  <= '0;
      rdata_q <= '0;
      kick_q  <= 1'b0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // Completion token and flags are single-cycle pulses.
      kick_q <= 1'b0;
      mis_q  <= 1'b0;
      to_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.ALU_kick_up) begin
            busy_q <= 1'b1;
            if (!mem_op) begin
              state_q <= ST_DONE;
              kick_q  <= 1'b1;
            end else if (st_mis) begin
              state_q <= ST_DONE;
              kick_q  <= 1'b1;
              mis_q   <= 1'b1;
            end else begin
              state_q <= ST_REQ;
              req_q   <= 1'b1;
              cnt_q   <= '0;
              we_q    <= bus.Controller_memwrite;
              addr_q  <= {bus.ALU_result[ADDR_W-1:LW], LW'(0)};
              wdata_q <= st_wdata;
              wstrb_q <= bus.Controller_memwrite ? st_wstrb : '0;
              size_q  <= size_in;
              uns_q   <= bus.Controller_memunsigned;
              lane_q  <= bus.ALU_result[LW-1:0];
            end
          end
        end
        ST_REQ: begin
          if (bus.Data_mem_ack) begin
            if (!we_q) rdata_q <= ld_data;
            req_q   <= 1'b0;
            kick_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_DONE;
          end else if (cnt_q == WAIT_CNT_W'(MAX_WAIT - 1)) begin
            req_q   <= 1'b0;
            kick_q  <= 1'b1;
            to_q    <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.Data_mem_req   = req_q;
  assign bus.Data_mem_we    = we_q;
  assign bus.Data_mem_addr  = addr_q;
  assign bus.Data_mem_wdata = wdata_q;
  assign bus.Data_mem_wstrb = wstrb_q;
  assign bus.MEM_read_data  = rdata_q;
  assign bus.MEM_kick_up    = kick_q;
  assign bus.MEM_misaligned = mis_q;
  assign bus.MEM_timeout    = to_q;
  assign bus.MEM_busy       = busy_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: the driver queues expected memory
// requests and completions, a memory responder and a completion monitor check them.
module tb_mem_access_unit;
  localparam int XLEN     = 32;
  localparam int ADDR_W   = 32;
  localparam int MAX_WAIT = 15;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

  mem_access_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  // delay >= 0: ack after that many extra cycles; -1: never ack; -2: reset abort
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          delay;
    logic [31:0] rdata;
  } req_t;

  typedef struct {
    logic [31:0] data;
    logic        mis;
    logic        to;
    int          cyc;
  } done_t;

  req_t        req_q[$];
  done_t       done_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] last_load = 32'h0;
  done_t       mon_e;
  req_t        rsp_e;
  logic        rsp_active = 1'b0;
  logic        rsp_acked = 1'b0;
  int          rsp_cycles = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input int lane,
                                             input int n, input bit uns);
    longint v;
    v = (longint'(rdata) >> (8 * lane)) & ((64'sd1 <<< (8 * n)) - 1);
    if (!uns && n < 4 && v >= (64'sd1 <<< (8 * n - 1))) v = v - (64'sd1 <<< (8 * n));
    return 32'(v);
  endfunction

  // Completion monitor
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && bus.MEM_kick_up === 1'b1) begin
        if (done_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_kick: got MEM_kick_up with nothing pending at cycle %0d", cyc);
        end else begin
          mon_e = done_q.pop_front();
          check("read_data", bus.MEM_read_data, mon_e.data);
          check("misaligned", bus.MEM_misaligned, mon_e.mis);
          check("timeout", bus.MEM_timeout, mon_e.to);
          check("kick_cycle", cyc, mon_e.cyc);
        end
      end else if (reset === 1'b1) begin
        check("flags_idle", {bus.MEM_misaligned, bus.MEM_timeout}, 2'b00);
      end
    end
  end

  // Data-memory responder
  initial begin
    bus.Data_mem_ack   = 1'b0;
    bus.Data_mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.Data_mem_req === 1'b1) begin
        if (!rsp_active) begin
          rsp_active = 1'b1;
          rsp_acked  = 1'b0;
          rsp_cycles = 0;
          if (req_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_req: got request to 0x%0h with nothing queued", bus.Data_mem_addr);
            rsp_e = '{addr: 32'h0, we: 1'b0, wdata: 32'h0, wstrb: 4'h0, delay: -2, rdata: 32'h0};
          end else begin
            rsp_e = req_q.pop_front();
            check("req_addr", bus.Data_mem_addr, rsp_e.addr);
            check("req_we", bus.Data_mem_we, rsp_e.we);
            check("req_wstrb", bus.Data_mem_wstrb, rsp_e.wstrb);
            if (rsp_e.we) check("req_wdata", bus.Data_mem_wdata, rsp_e.wdata);
          end
        end else begin
          check("hold_addr", bus.Data_mem_addr, rsp_e.addr);
          check("hold_we", bus.Data_mem_we, rsp_e.we);
          check("hold_wstrb", bus.Data_mem_wstrb, rsp_e.wstrb);
          if (rsp_e.we) check("hold_wdata", bus.Data_mem_wdata, rsp_e.wdata);
        end
        if (rsp_e.delay >= 0 && rsp_cycles == rsp_e.delay) begin
          bus.Data_mem_ack   = 1'b1;
          bus.Data_mem_rdata = rsp_e.rdata;
          rsp_acked          = 1'b1;
        end else begin
          bus.Data_mem_ack   = 1'b0;
          bus.Data_mem_rdata = $urandom;
        end
        rsp_cycles++;
      end else begin
        if (rsp_active) begin
          if (rsp_acked) check("req_length", rsp_cycles, rsp_e.delay + 1);
          else if (rsp_e.delay == -1) check("timeout_req_length", rsp_cycles, MAX_WAIT);
          rsp_active = 1'b0;
        end
        // Stray acks while no request is outstanding must be ignored.
        bus.Data_mem_ack   = ($urandom_range(0, 3) == 0);
        bus.Data_mem_rdata = $urandom;
      end
    end
  end

  task automatic drive_idle();
    bus.ALU_kick_up            = 1'b0;
    bus.ALU_result             = $urandom;
    bus.reg_read_data_2        = $urandom;
    bus.Controller_memwrite    = 1'($urandom);
    bus.Controller_memread     = 1'($urandom);
    bus.Controller_memsize     = 2'($urandom);
    bus.Controller_memunsigned = 1'($urandom);
  endtask

  task automatic drive_kick(input bit wr, input bit rd, input logic [31:0] addr,
                            input logic [31:0] data, input int size, input bit uns);
    bus.ALU_kick_up            = 1'b1;
    bus.ALU_result             = addr;
    bus.reg_read_data_2        = data;
    bus.Controller_memwrite    = wr;
    bus.Controller_memread     = rd;
    bus.Controller_memsize     = 2'(size);
    bus.Controller_memunsigned = uns;
  endtask

  task automatic start_txn(input bit wr, input bit rd, input logic [31:0] addr,
                           input logic [31:0] data, input int size, input bit uns,
                           input int delay, input logic [31:0] rdata);
    int   n;
    int   lane;
    int   c;
    bit   mis;
    req_t r;
    n    = 1 << size;
    lane = int'(addr % 4);
    mis  = (size == 3) || ((addr % n) != 0);
    @(posedge clk);
    #1;
    c = cyc;
    if (!(wr || rd) || mis) begin
      done_q.push_back('{data: last_load, mis: mis && (wr || rd), to: 1'b0, cyc: c + 1});
    end else begin
      r.addr  = addr & ~32'h3;
      r.we    = wr;
      r.wdata = 32'(longint'(data) << (8 * lane));
      r.wstrb = wr ? 4'(((1 << n) - 1) << lane) : 4'h0;
      r.delay = delay;
      r.rdata = rdata;
      req_q.push_back(r);
      if (delay < 0) begin
        done_q.push_back('{data: last_load, mis: 1'b0, to: 1'b1, cyc: c + 1 + MAX_WAIT});
      end else begin
        if (!wr) last_load = model_load(rdata, lane, n, uns);
        done_q.push_back('{data: last_load, mis: 1'b0, to: 1'b0, cyc: c + 2 + delay});
      end
    end
    drive_kick(wr, rd, addr, data, size, uns);
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && done_q.size() != 0; i++) @(posedge clk);
    #1;
    checks++;
    if (done_q.size() != 0) begin
      failures++;
      $display("FAIL completion_wait: got %0d completions still pending, required 0", done_q.size());
      done_q.delete();
      req_q.delete();
    end
  endtask

  task automatic do_txn(input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] data, input int size, input bit uns,
                        input int delay, input logic [31:0] rdata);
    start_txn(wr, rd, addr, data, size, uns, delay, rdata);
    wait_done();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   op;
    int   size;
    int   delay;
    logic [31:0] addr;
    drive_idle();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", bus.Data_mem_req, 1'b0);
    check("rst_kick", bus.MEM_kick_up, 1'b0);
    check("rst_busy", bus.MEM_busy, 1'b0);
    check("rst_read_data", bus.MEM_read_data, 32'h0);
    check("rst_flags", {bus.MEM_misaligned, bus.MEM_timeout}, 2'b00);
    check("rst_wstrb", bus.Data_mem_wstrb, 4'h0);
    check("rst_addr", bus.Data_mem_addr, 32'h0);
    reset = 1'b1;

    do_txn(1'b1, 1'b0, 32'h104, 32'hDEADBEEF, 2, 1'b0, 2, 32'h0);
    do_txn(1'b1, 1'b0, 32'h103, 32'h123456A5, 0, 1'b0, 1, 32'h0);
    do_txn(1'b0, 1'b1, 32'h102, 32'h0, 1, 1'b0, 0, 32'h80010000);
    check("lh_value", bus.MEM_read_data, 32'hFFFF8001);
    do_txn(1'b0, 1'b1, 32'h102, 32'h0, 1, 1'b1, 3, 32'h80010000);
    check("lhu_value", bus.MEM_read_data, 32'h00008001);
    do_txn(1'b0, 1'b1, 32'h102, 32'h0, 2, 1'b0, 0, 32'h0);
    do_txn(1'b0, 1'b0, 32'h777, 32'h0, 2, 1'b0, 0, 32'h0);
    do_txn(1'b0, 1'b1, 32'h200, 32'h0, 2, 1'b0, -1, 32'h0);
    check("timeout_keeps_data", bus.MEM_read_data, 32'h00008001);

    // A second token during an outstanding request must not disturb it.
    start_txn(1'b0, 1'b1, 32'h300, 32'h0, 2, 1'b0, 4, 32'hCAFEF00D);
    check("busy_in_req", bus.MEM_busy, 1'b1);
    drive_kick(1'b1, 1'b0, 32'h400, 32'h11223344, 2, 1'b0);
    @(posedge clk);
    #1;
    drive_idle();
    wait_done();
    check("busy_load_value", bus.MEM_read_data, 32'hCAFEF00D);

    start_txn(1'b0, 1'b1, 32'h500, 32'h0, 2, 1'b0, -2, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("busy_before_reset", bus.Data_mem_req, 1'b1);
    done_q.delete();
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("reset_req_drop", bus.Data_mem_req, 1'b0);
    check("reset_busy_drop", bus.MEM_busy, 1'b0);
    check("reset_no_kick", bus.MEM_kick_up, 1'b0);
    check("reset_read_data", bus.MEM_read_data, 32'h0);
    reset = 1'b1;
    last_load = 32'h0;
    repeat (4) @(posedge clk);

    for (int k = 0; k < 150; k++) begin
      op    = $urandom_range(0, 3);
      size  = $urandom_range(0, 3);
      addr  = $urandom;
      if ($urandom_range(0, 1) == 1) addr = addr & ~32'h7;
      delay = ($urandom_range(0, 15) == 0) ? -1 : $urandom_range(0, 4);
      do_txn(op >= 2, (op % 2) == 1, addr, $urandom, size, 1'($urandom), delay, $urandom);
    end

    repeat (5) @(posedge clk);
    #1;
    check("queues_drained", req_q.size() + done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
